// File: rtl/crypto_wallet_pio_master.sv
// Avalon-MM master for the crypto_wallet PIO s1 port: one valid/ready command in, one bus access, one response out.
// Optional feature macro: PIO_MASTER_POLL_EN (op 10 repeats masked-compare reads with idle gaps and a timeout).
module crypto_wallet_pio_master #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_MAX     = 1024,
  parameter int POLL_GAP     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WR, RD, RESP, GAP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [2:0] RD_LAST  = 3'(READ_LATENCY);

  state_t      state;
  state_t      next_state;
  logic [1:0]  addr_q;
  logic [31:0] data_q;
  logic [2:0]  rd_cnt;
  logic        last_rd;
  logic        poll_retry;

  logic        chipselect_d;
  logic        write_n_d;
  logic [1:0]  address_d;
  logic [31:0] writedata_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_data_d;

`ifdef PIO_MASTER_POLL_EN
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [1:0]       OP_POLL   = 2'b10;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);

  logic [1:0]       op_q;
  logic [31:0]      mask_q;
  logic [CNT_W-1:0] attempt_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             poll_op;
  logic             poll_hit;
  logic             rsp_timeout_d;

  assign poll_op    = (op_q == OP_POLL);
  assign poll_hit   = ((readdata ^ data_q) & mask_q) == 32'd0;
  // Retry only while fewer than POLL_MAX attempts have completed.
  assign poll_retry = poll_op && !poll_hit && (attempt_cnt != POLL_LAST);
`else
  logic unused_cmd_mask;

  assign unused_cmd_mask = ^cmd_mask;
  assign poll_retry      = 1'b0;
  assign rsp_timeout     = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last_rd   = (state == RD) && (rd_cnt == RD_LAST);

  // State, command latch, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_cnt     <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= '0;
      writedata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
`ifdef PIO_MASTER_POLL_EN
      op_q        <= '0;
      mask_q      <= '0;
      attempt_cnt <= '0;
      gap_cnt     <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      chipselect <= chipselect_d;
      write_n    <= write_n_d;
      address    <= address_d;
      writedata  <= writedata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      if (state == IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      rd_cnt <= (state == RD && !last_rd) ? rd_cnt + 3'd1 : 3'd0;
`ifdef PIO_MASTER_POLL_EN
      rsp_timeout <= rsp_timeout_d;
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        mask_q <= cmd_mask;
      end
      if (state == IDLE)
        attempt_cnt <= '0;
      else if (last_rd)
        attempt_cnt <= attempt_cnt + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_valid) next_state = (cmd_op == OP_WRITE) ? WR : RD;
      WR:   next_state = RESP;
      RD:   if (last_rd) next_state = poll_retry ? GAP : RESP;
      RESP: if (rsp_ready) next_state = IDLE;
`ifdef PIO_MASTER_POLL_EN
      GAP:  if (gap_cnt == GAP_LAST) next_state = RD;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed from next_state so they line up with the state they belong to.
  always_comb begin
    chipselect_d = (next_state == WR) || (next_state == RD);
    write_n_d    = (next_state != WR);
    address_d    = '0;
    if (chipselect_d)
      address_d = (state == IDLE) ? cmd_addr : addr_q;
    writedata_d  = (next_state == WR) ? cmd_data : 32'd0;
    rsp_valid_d  = (next_state == RESP);
    rsp_data_d   = rsp_data;
    if (state == WR)
      rsp_data_d = data_q;
    else if (last_rd)
      rsp_data_d = readdata;
`ifdef PIO_MASTER_POLL_EN
    rsp_timeout_d = rsp_timeout;
    if (state == WR)
      rsp_timeout_d = 1'b0;
    else if (last_rd)
      rsp_timeout_d = poll_op && !poll_hit;
`endif
  end

endmodule

// File: tb/tb_crypto_wallet_pio_master.sv
// Directed self-checking bench for crypto_wallet_pio_master with a registered-readdata PIO slave model.
// Poll scenarios run when PIO_MASTER_POLL_EN is defined; otherwise op 10 is checked as a plain read.
module tb_crypto_wallet_pio_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state: PIO registers, read-burst counter and poll-pattern selection.
  logic [31:0] pio_data = '0;
  logic [31:0] pio_dir  = '0;
  int          burst_cnt = 0;
  bit          prev_rd = 1'b0;
  int          poll_mode = 0;
  int          poll_base = 0;

  crypto_wallet_pio_master #(
    .READ_LATENCY(1),
    .POLL_MAX(4),
    .POLL_GAP(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO s1 slave with one cycle of read latency; poll modes replace readdata with a scripted pattern.
  always @(posedge clk) begin
    int nb;
    nb = burst_cnt;
    if (chipselect && write_n && !prev_rd) nb = nb + 1;
    prev_rd   <= chipselect && write_n;
    burst_cnt <= nb;
    if (chipselect && !write_n) begin
      if (address == 2'd0) pio_data <= writedata;
      else if (address == 2'd1) pio_dir <= writedata;
    end
    case (poll_mode)
      1:       readdata <= (nb - poll_base >= 3) ? 32'h0000_0010 : 32'h0000_0000;
      2:       readdata <= 32'hCAFE_0000 | 32'(nb - poll_base);
      default: readdata <= (address == 2'd1) ? pio_dir : pio_data;
    endcase
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] addr,
                               input logic [31:0] data, input logic [31:0] mask);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic handshake;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
  endtask

  task automatic watch_poll(output int bursts, output int len_bad, output int gap_bad,
                            output int wn_bad, output bit got);
    int  cur_len;
    int  gap_len;
    bit  prev_cs;
    bursts = 0; len_bad = 0; gap_bad = 0; wn_bad = 0; got = 1'b0;
    cur_len = 0; gap_len = 0; prev_cs = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        if (prev_cs && cur_len != 2) len_bad++;
      end else if (chipselect) begin
        if (!prev_cs) begin
          bursts++;
          if (bursts > 1 && gap_len != 8) gap_bad++;
          cur_len = 0;
        end
        cur_len++;
        if (!write_n) wn_bad++;
      end else begin
        if (prev_cs) begin
          if (cur_len != 2) len_bad++;
          gap_len = 0;
        end
        gap_len++;
      end
      prev_cs = chipselect;
    end
  endtask

  task automatic test_reset;
    int cs_seen = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (chipselect) cs_seen++;
    end
    n_tests++;
    if ({chipselect, write_n, address, writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_bus: got cs=%b wn=%b addr=%0d wd=%h, want cs=0 wn=1 addr=0 wd=0",
               chipselect, write_n, address, writedata);
    end
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_timeout, busy, cmd_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp: got rv=%b rd=%h to=%b busy=%b rdy=%b, want 0 0 0 0 1",
               rsp_valid, rsp_data, rsp_timeout, busy, cmd_ready);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (chipselect) cs_seen++;
    end
    n_tests++;
    if (cs_seen !== 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got cs_cycles=%0d rdy=%b, want 0 and 1", cs_seen, cmd_ready);
    end
  endtask

  task automatic test_write;
    applyStimulus(2'b00, 2'd1, 32'h0000_00FF, 32'd0);
    @(negedge clk);
    n_tests++;
    if ({chipselect, write_n, address, writedata, rsp_valid} !== {1'b1, 1'b0, 2'd1, 32'h0000_00FF, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL write_bus: got cs=%b wn=%b addr=%0d wd=%h rv=%b, want 1 0 1 000000ff 0",
               chipselect, write_n, address, writedata, rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({chipselect, write_n, address, writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL write_idle_bus: got cs=%b wn=%b addr=%0d wd=%h, want 0 1 0 0",
               chipselect, write_n, address, writedata);
    end
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_timeout, cmd_ready, busy} !== {1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL write_rsp: got rv=%b rd=%h to=%b rdy=%b busy=%b, want 1 000000ff 0 0 1",
               rsp_valid, rsp_data, rsp_timeout, cmd_ready, busy);
    end
    handshake();
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, cmd_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL write_done: got rv=%b rdy=%b busy=%b, want 0 1 0", rsp_valid, cmd_ready, busy);
    end
    if (pio_dir !== 32'h0000_00FF) begin
      n_fail++;
      $display("[TB] FAIL write_slave: got dir=%h, want 000000ff", pio_dir);
    end
    n_tests++;
  endtask

  task automatic test_read_backpressure;
    bit got;
    applyStimulus(2'b00, 2'd0, 32'hA5A5_1234, 32'd0);
    wait_rsp(got);
    handshake();
    applyStimulus(2'b01, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_tests++;
    if ({chipselect, write_n, address, writedata, rsp_valid} !== {1'b1, 1'b1, 2'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL read_c1: got cs=%b wn=%b addr=%0d wd=%h rv=%b, want 1 1 0 0 0",
               chipselect, write_n, address, writedata, rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({chipselect, write_n, rsp_valid} !== {1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL read_c2: got cs=%b wn=%b rv=%b, want 1 1 0", chipselect, write_n, rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_data, cmd_ready, chipselect} !== {1'b1, 32'hA5A5_1234, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL read_hold%0d: got rv=%b rd=%h rdy=%b cs=%b, want 1 a5a51234 0 0",
                 i, rsp_valid, rsp_data, cmd_ready, chipselect);
      end
    end
    handshake();
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, cmd_ready} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL read_done: got rv=%b rdy=%b, want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_read;
    bit got;
    int rv_seen = 0;
    applyStimulus(2'b01, 2'd1, 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({chipselect, rsp_valid, busy} !== {1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL abort_bus: got cs=%b rv=%b busy=%b, want 0 0 0", chipselect, rsp_valid, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || chipselect) rv_seen++;
    end
    n_tests++;
    if (rv_seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: got %0d active cycles, want 0", rv_seen);
    end
    // Reserved op is a read; the direction register still holds the earlier write.
    applyStimulus(2'b11, 2'd1, 32'd0, 32'd0);
    wait_rsp(got);
    n_tests++;
    if (!got || rsp_data !== 32'h0000_00FF || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_abort_read: got valid=%b rd=%h to=%b, want 1 000000ff 0",
               got, rsp_data, rsp_timeout);
    end
    handshake();
  endtask

`ifdef PIO_MASTER_POLL_EN
  task automatic test_poll_match;
    int bursts, len_bad, gap_bad, wn_bad;
    bit got;
    poll_base = burst_cnt;
    poll_mode = 1;
    applyStimulus(2'b10, 2'd0, 32'h0000_0010, 32'h0000_0010);
    watch_poll(bursts, len_bad, gap_bad, wn_bad, got);
    n_tests++;
    if (!got || bursts != 3 || len_bad != 0 || gap_bad != 0 || wn_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL poll_match_bus: got valid=%b bursts=%0d len_bad=%0d gap_bad=%0d wn_bad=%0d, want 1 3 0 0 0",
               got, bursts, len_bad, gap_bad, wn_bad);
    end
    n_tests++;
    if (rsp_data !== 32'h0000_0010 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL poll_match_rsp: got rd=%h to=%b, want 00000010 0", rsp_data, rsp_timeout);
    end
    handshake();
    poll_mode = 0;
  endtask

  task automatic test_poll_timeout;
    int bursts, len_bad, gap_bad, wn_bad;
    bit got;
    poll_base = burst_cnt;
    poll_mode = 2;
    applyStimulus(2'b10, 2'd0, 32'h0000_0010, 32'h0000_0010);
    watch_poll(bursts, len_bad, gap_bad, wn_bad, got);
    n_tests++;
    if (!got || bursts != 4 || len_bad != 0 || gap_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL poll_timeout_bus: got valid=%b bursts=%0d len_bad=%0d gap_bad=%0d, want 1 4 0 0",
               got, bursts, len_bad, gap_bad);
    end
    n_tests++;
    if (rsp_data !== 32'hCAFE_0004 || rsp_timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL poll_timeout_rsp: got rd=%h to=%b, want cafe0004 1", rsp_data, rsp_timeout);
    end
    handshake();
    poll_base = burst_cnt;
    applyStimulus(2'b10, 2'd0, 32'h0000_0010, 32'h0000_0000);
    watch_poll(bursts, len_bad, gap_bad, wn_bad, got);
    n_tests++;
    if (!got || bursts != 1 || rsp_data !== 32'hCAFE_0001 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL poll_mask0: got valid=%b bursts=%0d rd=%h to=%b, want 1 1 cafe0001 0",
               got, bursts, rsp_data, rsp_timeout);
    end
    handshake();
    poll_mode = 0;
  endtask
`else
  task automatic test_poll_as_read;
    applyStimulus(2'b10, 2'd1, 32'h0000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({chipselect, rsp_valid} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL poll_plain_c2: got cs=%b rv=%b, want 1 0", chipselect, rsp_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_timeout, chipselect} !== {1'b1, 32'h0000_00FF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL poll_plain_rsp: got rv=%b rd=%h to=%b cs=%b, want 1 000000ff 0 0",
               rsp_valid, rsp_data, rsp_timeout, chipselect);
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
`ifdef PIO_MASTER_POLL_EN
    test_poll_match();
    test_poll_timeout();
`else
    test_poll_as_read();
`endif
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
